// File: rtl/subleq_pkg.sv
// Shared types and helpers for the SUBLEQ core.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package subleq_pkg;

  typedef enum logic [2:0] {
    FETCH_A   = 3'd0,
    DEREF_A   = 3'd1,
    FETCH_B   = 3'd2,
    DEREF_B   = 3'd3,
    STORE_SUB = 3'd4,
    FETCH_C   = 3'd5,
    HALT      = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'd0,
    CAUSE_SELF_LOOP = 2'd1,
    CAUSE_DEBUG     = 2'd2,
    CAUSE_STEP_DONE = 2'd3
  } halt_cause_t;

  // Widest word the leq helper handles; callers zero-extend to this width.
  localparam int unsigned LEQ_MAX_W = 64;

  // Two's-complement "less than or equal to zero" for a word of any width
  // up to LEQ_MAX_W; the sign bit is located by a shifted mask.
  function automatic logic leq_of(input logic [LEQ_MAX_W-1:0] res,
                                  input int unsigned          width);
    logic [LEQ_MAX_W-1:0] sign_mask;
    sign_mask = LEQ_MAX_W'(1) << (width - 1);
    return ((res & sign_mask) != '0) || (res == '0);
  endfunction

endpackage

// File: rtl/subleq_ctrl.sv
// SUBLEQ sequencer: instruction FSM, debug halt/step/resume and halt cause.
// Latency: one state per completed access; HALT entry/exit on a single edge.
// Backpressure: holds the current state while an access waits for mem_ready.
module subleq_ctrl
  import subleq_pkg::*;
(
  input  logic        clk,
  input  logic        areset,
  input  logic        mem_ready,
  input  logic        leq,
  input  logic        c_eq_pc,
  input  logic        dbg_halt_req,
  input  logic        dbg_step,
  input  logic        dbg_resume,
  output state_t      state,
  output logic        access,
  output logic        advance,
  output logic        halted,
  output halt_cause_t halt_cause
);

  state_t      state_q, state_d;
  halt_cause_t cause_q, cause_d;
  logic        step_q, step_d;

  // Which states touch memory, and whether the current state completes now.
  // A not-taken FETCH_C has no access and always completes in one cycle.
  always_comb begin
    access = 1'b0;
    case (state_q)
      FETCH_A, DEREF_A, FETCH_B, DEREF_B, STORE_SUB: access = 1'b1;
      FETCH_C: access = leq;
      default: access = 1'b0;
    endcase
    advance = (state_q != HALT) && (!access || mem_ready);
  end

  // Next-state, halt cause and single-step bookkeeping.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    step_d  = step_q;
    case (state_q)
      FETCH_A:   if (advance) state_d = DEREF_A;
      DEREF_A:   if (advance) state_d = FETCH_B;
      FETCH_B:   if (advance) state_d = DEREF_B;
      DEREF_B:   if (advance) state_d = STORE_SUB;
      STORE_SUB: if (advance) state_d = FETCH_C;
      FETCH_C: begin
        if (advance) begin
          // Instruction boundary: self-loop beats a pending step, which
          // beats a debug halt request.
          step_d = 1'b0;
          if (leq && c_eq_pc) begin
            state_d = HALT;
            cause_d = CAUSE_SELF_LOOP;
          end else if (step_q) begin
            state_d = HALT;
            cause_d = CAUSE_STEP_DONE;
          end else if (dbg_halt_req) begin
            state_d = HALT;
            cause_d = CAUSE_DEBUG;
          end else begin
            state_d = FETCH_A;
          end
        end
      end
      HALT: begin
        if (dbg_step) begin
          state_d = FETCH_A;
          step_d  = 1'b1;
        end else if (dbg_resume) begin
          state_d = FETCH_A;
          cause_d = CAUSE_NONE;
        end
      end
      default: state_d = FETCH_A;
    endcase
  end

  // State, cause and step flag registers.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= FETCH_A;
      cause_q <= CAUSE_NONE;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      step_q  <= step_d;
    end
  end

  assign state      = state_q;
  assign halted     = (state_q == HALT);
  assign halt_cause = cause_q;

endmodule

// File: rtl/subleq_core.sv
// Parametrised SUBLEQ core with a ready-handshaked memory port and debug control.
// Latency: 6 cycles per instruction with zero wait states, +1 per wait cycle.
// Backpressure: memory request fields hold stable until mem_ready completes the access.
module subleq_core
  import subleq_pkg::*;
#(
  parameter int unsigned            WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0]   RESET_PC  = '0,
  parameter int unsigned            CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 areset,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_ready,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 dbg_halt_req,
  input  logic                 dbg_step,
  input  logic                 dbg_resume,
  output logic                 halted,
  output logic [1:0]           halt_cause,
  output logic [WORD_SIZE-1:0] pc,
  output logic [CNT_WIDTH-1:0] retired
);

  state_t      state;
  halt_cause_t cause;
  logic        access;
  logic        advance;
  logic        leq;
  logic        c_eq_pc;

  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] a_addr_q, a_addr_d;
  logic [WORD_SIZE-1:0] a_val_q, a_val_d;
  logic [WORD_SIZE-1:0] b_addr_q, b_addr_d;
  logic [WORD_SIZE-1:0] b_val_q, b_val_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic [WORD_SIZE-1:0] res;

  // Subtract result and branch condition; operands are held until the
  // instruction retires, so leq stays valid through a stalled FETCH_C.
  always_comb begin
    res     = b_val_q - a_val_q;
    leq     = leq_of(LEQ_MAX_W'(res), WORD_SIZE);
    c_eq_pc = (mem_rdata == pc_q);
  end

  subleq_ctrl ctrl (
    .clk          (clk),
    .areset       (areset),
    .mem_ready    (mem_ready),
    .leq          (leq),
    .c_eq_pc      (c_eq_pc),
    .dbg_halt_req (dbg_halt_req),
    .dbg_step     (dbg_step),
    .dbg_resume   (dbg_resume),
    .state        (state),
    .access       (access),
    .advance      (advance),
    .halted       (halted),
    .halt_cause   (cause)
  );

  // Memory port; reset forces every field low at once so an in-flight
  // write is abandoned the moment areset rises.
  always_comb begin
    mem_req   = access && !areset;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_req) begin
      case (state)
        FETCH_A:   mem_addr = pc_q;
        DEREF_A:   mem_addr = a_addr_q;
        FETCH_B:   mem_addr = pc_q + WORD_SIZE'(1);
        DEREF_B:   mem_addr = b_addr_q;
        STORE_SUB: begin
          mem_addr  = b_addr_q;
          mem_we    = 1'b1;
          mem_wdata = res;
        end
        FETCH_C:   mem_addr = pc_q + WORD_SIZE'(2);
        default:   mem_addr = '0;
      endcase
    end
  end

  // Datapath capture on each completing edge; pc and retired move together.
  always_comb begin
    pc_d      = pc_q;
    a_addr_d  = a_addr_q;
    a_val_d   = a_val_q;
    b_addr_d  = b_addr_q;
    b_val_d   = b_val_q;
    retired_d = retired_q;
    if (advance) begin
      case (state)
        FETCH_A: a_addr_d = mem_rdata;
        DEREF_A: a_val_d  = mem_rdata;
        FETCH_B: b_addr_d = mem_rdata;
        DEREF_B: b_val_d  = mem_rdata;
        FETCH_C: begin
          pc_d      = leq ? mem_rdata : pc_q + WORD_SIZE'(3);
          retired_d = retired_q + CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      pc_q      <= RESET_PC;
      a_addr_q  <= '0;
      a_val_q   <= '0;
      b_addr_q  <= '0;
      b_val_q   <= '0;
      retired_q <= '0;
    end else begin
      pc_q      <= pc_d;
      a_addr_q  <= a_addr_d;
      a_val_q   <= a_val_d;
      b_addr_q  <= b_addr_d;
      b_val_q   <= b_val_d;
      retired_q <= retired_d;
    end
  end

  assign pc         = pc_q;
  assign retired    = retired_q;
  assign halt_cause = cause;

endmodule
